spram_uart_monitor: RTL and testbench

Byte-command responder that gives a host on the serial link direct read/write access to the 16-bit single-port SPRAM. It sits between the `uart_rx` byte stream and the `uart_tx` byte handshake, parses fixed-format commands, drives the SPRAM port (never reading and writing in the same cycle), and streams responses back. It is the host-facing counterpart to the FIFO demos: there the FPGA writes the SPRAM, here the remote end does.

---
 rtl/spram_uart_monitor_pkg.sv | 24 ++
 rtl/spram_uart_monitor_inter_byte_timer.sv | 31 +++
 rtl/spram_uart_monitor.sv | 162 ++++++++++++++++
 tb/tb_spram_uart_monitor.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spram_uart_monitor_pkg.sv
// Shared constants and FSM state encoding for the SPRAM UART monitor.
// Command bytes, reply bytes, SPRAM geometry.
package spram_uart_monitor_pkg;

    localparam int SPRAM_AW = 14;
    localparam int SPRAM_DW = 16;

    localparam logic [7:0] CMD_W   = 8'h57;
    localparam logic [7:0] CMD_R   = 8'h52;
    localparam logic [7:0] ACK_OK  = 8'h2B;
    localparam logic [7:0] ACK_ERR = 8'h3F;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARGS,
        ST_WRITE,
        ST_RD_ADDR,
        ST_RD_CAP,
        ST_SEND_HI,
        ST_SEND_LO,
        ST_ACK
    } state_t;

endpackage

// File: rtl/spram_uart_monitor_inter_byte_timer.sv
// Inter-byte timeout: cleared by every received byte, counts idle cycles
// while enabled. Ports: clk, reset (async low), enable, load, expire.
module inter_byte_timer #(
    parameter int unsigned TIMEOUT = 4_800_000
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic load,
    output logic expire
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] count;

    // expire fires on the TIMEOUT-th idle cycle after the last byte;
    // a byte in that same cycle suppresses it.
    assign expire = enable && !load && (count == CW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (load || !enable) begin
            count <= '0;
        end else if (!expire) begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/spram_uart_monitor.sv
// Host-facing byte-command responder giving read/write access to the SPRAM.
// Ports: rx byte stream in, tx byte handshake out, SPRAM port, busy/overrun.
module spram_uart_monitor
    import spram_uart_monitor_pkg::*;
#(
    parameter int unsigned TIMEOUT = 4_800_000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [7:0]          rx_data,
    input  logic                rx_strobe,
    output logic [7:0]          tx_data,
    output logic                tx_strobe,
    input  logic                tx_ready,
    output logic [SPRAM_AW-1:0] spram_addr,
    output logic [SPRAM_DW-1:0] spram_wdata,
    output logic                spram_wren,
    input  logic [SPRAM_DW-1:0] spram_rdata,
    output logic                busy,
    output logic                overrun
);

    state_t        state;
    logic          is_write;
    logic [1:0]    arg_idx;
    logic [5:0]    a_hi;
    logic [7:0]    a_lo;
    logic [7:0]    d_hi;
    logic [7:0]    ack_byte;
    logic [7:0]    remaining;
    logic [SPRAM_DW-1:0] rd_word;
    logic          expired;

    inter_byte_timer #(
        .TIMEOUT(TIMEOUT)
    ) u_timer (
        .clk   (clk),
        .reset (reset),
        .enable(state == ST_ARGS),
        .load  (rx_strobe),
        .expire(expired)
    );

    // Held high through the final strobe cycle so it drops one cycle later.
    assign busy = (state != ST_IDLE) || tx_strobe;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            is_write    <= 1'b0;
            arg_idx     <= 2'd0;
            a_hi        <= 6'd0;
            a_lo        <= 8'd0;
            d_hi        <= 8'd0;
            ack_byte    <= 8'd0;
            remaining   <= 8'd0;
            rd_word     <= '0;
            tx_data     <= 8'd0;
            tx_strobe   <= 1'b0;
            spram_addr  <= '0;
            spram_wdata <= '0;
            spram_wren  <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            tx_strobe  <= 1'b0;
            spram_wren <= 1'b0;
            if (rx_strobe && state != ST_IDLE && state != ST_ARGS) begin
                overrun <= 1'b1;
            end
            unique case (state)
                ST_IDLE: begin
                    if (rx_strobe) begin
                        is_write <= (rx_data == CMD_W);
                        arg_idx  <= 2'd0;
                        if (rx_data == CMD_W || rx_data == CMD_R) begin
                            state <= ST_ARGS;
                        end else begin
                            ack_byte <= ACK_ERR;
                            state    <= ST_ACK;
                        end
                    end
                end
                ST_ARGS: begin
                    if (rx_strobe) begin
                        arg_idx <= arg_idx + 2'd1;
                        unique case (arg_idx)
                            2'd0: a_hi <= rx_data[5:0];
                            2'd1: a_lo <= rx_data;
                            2'd2: begin
                                if (is_write) begin
                                    d_hi <= rx_data;
                                end else begin
                                    spram_addr <= {a_hi, a_lo};
                                    remaining  <= rx_data;
                                    state      <= ST_RD_ADDR;
                                end
                            end
                            default: begin
                                spram_addr  <= {a_hi, a_lo};
                                spram_wdata <= {d_hi, rx_data};
                                spram_wren  <= 1'b1;
                                state       <= ST_WRITE;
                            end
                        endcase
                    end else if (expired) begin
                        state <= ST_IDLE;
                    end
                end
                ST_WRITE: begin
                    ack_byte <= ACK_OK;
                    state    <= ST_ACK;
                end
                ST_RD_ADDR: begin
                    state <= ST_RD_CAP;
                end
                ST_RD_CAP: begin
                    rd_word <= spram_rdata;
                    // Launch the hi byte straight from the read port when
                    // the transmitter is already idle.
                    if (tx_ready) begin
                        tx_data   <= spram_rdata[15:8];
                        tx_strobe <= 1'b1;
                        state     <= ST_SEND_LO;
                    end else begin
                        state <= ST_SEND_HI;
                    end
                end
                ST_SEND_HI: begin
                    if (tx_ready && !tx_strobe) begin
                        tx_data   <= rd_word[15:8];
                        tx_strobe <= 1'b1;
                        state     <= ST_SEND_LO;
                    end
                end
                ST_SEND_LO: begin
                    // tx_strobe high here means the hi byte just launched;
                    // tx_ready is stale for that cycle.
                    if (tx_ready && !tx_strobe) begin
                        tx_data   <= rd_word[7:0];
                        tx_strobe <= 1'b1;
                        if (remaining == 8'd0) begin
                            state <= ST_IDLE;
                        end else begin
                            remaining  <= remaining - 8'd1;
                            spram_addr <= spram_addr + 14'd1;
                            state      <= ST_RD_ADDR;
                        end
                    end
                end
                ST_ACK: begin
                    if (tx_ready && !tx_strobe) begin
                        tx_data   <= ack_byte;
                        tx_strobe <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spram_uart_monitor.sv
// Self-checking bench for spram_uart_monitor: directed table, random
// commands against a reference memory model, timeout/overrun/reset sequences.
module tb_spram_uart_monitor;

    localparam int unsigned TMO = 40;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  rx_data = 8'd0;
    logic        rx_strobe = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_strobe;
    logic        tx_ready;
    logic [13:0] spram_addr;
    logic [15:0] spram_wdata;
    logic        spram_wren;
    logic [15:0] spram_rdata;
    logic        busy;
    logic        overrun;

    always #5 clk = ~clk;

    spram_uart_monitor #(.TIMEOUT(TMO)) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_data    (rx_data),
        .rx_strobe  (rx_strobe),
        .tx_data    (tx_data),
        .tx_strobe  (tx_strobe),
        .tx_ready   (tx_ready),
        .spram_addr (spram_addr),
        .spram_wdata(spram_wdata),
        .spram_wren (spram_wren),
        .spram_rdata(spram_rdata),
        .busy       (busy),
        .overrun    (overrun)
    );

    // SPRAM with one-cycle registered read
    logic [15:0] mem [0:16383];
    logic        preload = 1'b0;
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 16384; i++) mem[i] <= 16'(i);
        end else if (spram_wren) begin
            mem[spram_addr] <= spram_wdata;
        end
        spram_rdata <= mem[spram_addr];
    end

    // Transmitter: goes not-ready for a random while after each strobe
    int hold;
    initial begin
        tx_ready = 1'b1;
        hold = 0;
        forever begin
            @(negedge clk);
            if (tx_strobe) begin
                tx_ready = 1'b0;
                hold = $urandom_range(1, 5);
            end else if (!tx_ready) begin
                if (hold <= 1) tx_ready = 1'b1;
                else hold--;
            end
        end
    end

    // Monitor
    int          cyc = 0;
    logic [7:0]  got_q[$];
    logic [7:0]  exp_q[$];
    int          first_tx = -1;
    int          last_rx = 0;
    int          wr_count = 0;
    int          dbl = 0;
    logic        prev_strobe = 1'b0;
    logic [13:0] wr_addr = '0;
    logic [15:0] wr_data = '0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rx_strobe) last_rx = cyc;
        if (tx_strobe) begin
            got_q.push_back(tx_data);
            if (first_tx < 0) first_tx = cyc;
            if (prev_strobe) dbl++;
        end
        prev_strobe = tx_strobe;
        if (spram_wren) begin
            wr_count++;
            wr_addr = spram_addr;
            wr_data = spram_wdata;
        end
    end

    int checks = 0;
    int failures = 0;
    int wr0 = 0;

    task automatic check_val(input string name, input logic [63:0] act,
                             input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic check_bytes(input string name);
        string sa, sr;
        bit ok;
        checks++;
        ok = (got_q.size() == exp_q.size());
        sa = "";
        sr = "";
        foreach (got_q[k]) sa = {sa, $sformatf(" %02h", got_q[k])};
        foreach (exp_q[k]) begin
            sr = {sr, $sformatf(" %02h", exp_q[k])};
            if (ok && got_q[k] !== exp_q[k]) ok = 1'b0;
        end
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=[%s ] required=[%s ]", name, sa, sr);
        end
    endtask

    // Reference model: memory array plus the command rules
    logic [15:0] ref_mem [0:16383];

    task automatic model_cmd(input logic [39:0] cmd);
        int a, n;
        logic [15:0] w;
        a = int'({cmd[29:24], cmd[23:16]});
        if (cmd[39:32] == 8'h57) begin
            ref_mem[a] = cmd[15:0];
            exp_q.push_back(8'h2B);
        end else if (cmd[39:32] == 8'h52) begin
            n = int'(cmd[15:8]) + 1;
            for (int k = 0; k < n; k++) begin
                w = ref_mem[(a + k) % 16384];
                exp_q.push_back(w[15:8]);
                exp_q.push_back(w[7:0]);
            end
        end else begin
            exp_q.push_back(8'h3F);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int idle);
        rx_data = b;
        rx_strobe = 1'b1;
        @(posedge clk); #1;
        rx_strobe = 1'b0;
        repeat (idle) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_bytes(input string name, input int target);
        int t = 0;
        while (got_q.size() < target && t < 5000) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 5000) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout actual=%0d required=%0d",
                     name, got_q.size(), target);
        end
    endtask

    // Sends n bytes; byte index slot is followed by slot_idle idle cycles.
    task automatic run_cmd(input string name, input logic [39:0] cmd,
                           input int n, input int slot, input int slot_idle);
        int idle;
        got_q.delete();
        first_tx = -1;
        wr0 = wr_count;
        for (int k = 0; k < n; k++) begin
            if (k == slot) idle = slot_idle;
            else if (k == n - 1) idle = 0;
            else idle = $urandom_range(0, 2);
            send_byte(cmd[39-8*k -: 8], idle);
        end
        wait_bytes(name, exp_q.size());
        repeat (12) begin
            @(posedge clk); #1;
        end
    endtask

    typedef struct {
        logic [39:0] cmd;
        int          n;
        logic [63:0] exp;
        int          ne;
    } vec_t;

    vec_t        tbl[4];
    logic [39:0] cmd;
    logic [7:0]  c0;
    int          n0;

    initial begin
        tbl[0] = '{cmd: 40'h57_00_10_BE_EF, n: 5,
                   exp: 64'h2B00_0000_0000_0000, ne: 1};
        tbl[1] = '{cmd: 40'h52_00_10_00_00, n: 4,
                   exp: 64'hBEEF_0000_0000_0000, ne: 2};
        tbl[2] = '{cmd: 40'h52_3F_FE_03_00, n: 4,
                   exp: 64'h3FFE_3FFF_0000_0001, ne: 8};
        tbl[3] = '{cmd: 40'h41_00_00_00_00, n: 1,
                   exp: 64'h3F00_0000_0000_0000, ne: 1};

        for (int i = 0; i < 16384; i++) ref_mem[i] = 16'(i);

        preload = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_val("reset_outputs",
                  {tx_strobe, tx_data, spram_wren, spram_addr,
                   spram_wdata, busy, overrun}, 64'd0);
        preload = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Directed table
        for (int i = 0; i < 4; i++) begin
            model_cmd(tbl[i].cmd);
            exp_q.delete();
            for (int k = 0; k < tbl[i].ne; k++)
                exp_q.push_back(tbl[i].exp[63-8*k -: 8]);
            run_cmd($sformatf("vec%0d", i), tbl[i].cmd, tbl[i].n, -1, 0);
            check_bytes($sformatf("vec%0d_bytes", i));
            check_val($sformatf("vec%0d_writes", i), 64'(wr_count - wr0),
                      (tbl[i].cmd[39:32] == 8'h57) ? 64'd1 : 64'd0);
            check_val($sformatf("vec%0d_busy", i), 64'(busy), 64'd0);
            if (tbl[i].cmd[39:32] == 8'h52)
                check_val($sformatf("vec%0d_gap", i),
                          64'(first_tx - last_rx), 64'd3);
            if (i == 0)
                check_val("vec0_waddr", {wr_addr, wr_data},
                          {14'h0010, 16'hBEEF});
        end

        // Random commands against the model
        for (int r = 0; r < 24; r++) begin
            int kind, nb;
            kind = $urandom_range(0, 4);
            if (kind <= 1) begin
                cmd = {8'h57, 8'($urandom), 8'($urandom),
                       16'($urandom)};
                nb = 5;
            end else if (kind <= 3) begin
                cmd = {8'h52, 8'($urandom), 8'($urandom),
                       8'($urandom_range(0, 7)), 8'h00};
                nb = 4;
            end else begin
                c0 = 8'($urandom);
                if (c0 == 8'h57 || c0 == 8'h52) c0 = 8'h00;
                cmd = {c0, 32'h0};
                nb = 1;
            end
            exp_q.delete();
            model_cmd(cmd);
            run_cmd($sformatf("rnd%0d", r), cmd, nb, -1, 0);
            check_bytes($sformatf("rnd%0d_bytes", r));
            check_val($sformatf("rnd%0d_writes", r), 64'(wr_count - wr0),
                      (kind <= 1) ? 64'd1 : 64'd0);
            if (kind >= 2 && kind <= 3 && first_tx - last_rx < 3)
                check_val($sformatf("rnd%0d_gap", r),
                          64'(first_tx - last_rx), 64'd3);
        end

        // Partial W then silence: discarded without reply or write
        got_q.delete();
        wr0 = wr_count;
        send_byte(8'h57, 1);
        send_byte(8'h00, 1);
        send_byte(8'h20, 0);
        repeat (TMO + 10) begin
            @(posedge clk); #1;
        end
        check_val("tmo_no_reply", 64'(got_q.size()), 64'd0);
        check_val("tmo_no_write", 64'(wr_count - wr0), 64'd0);
        check_val("tmo_busy", 64'(busy), 64'd0);

        exp_q.delete();
        model_cmd(40'h52_00_20_00_00);
        run_cmd("tmo_after_r", 40'h52_00_20_00_00, 4, -1, 0);
        check_bytes("tmo_after_r_bytes");

        // Byte arriving on the expiry cycle still counts
        exp_q.delete();
        model_cmd(40'h57_00_30_12_34);
        run_cmd("tmo_edge_in", 40'h57_00_30_12_34, 5, 1, TMO - 1);
        check_bytes("tmo_edge_in_bytes");
        check_val("tmo_edge_in_write", {wr_addr, wr_data},
                  {14'h0030, 16'h1234});

        // One cycle later the command is gone; the late byte is a new one
        exp_q.delete();
        exp_q.push_back(8'h3F);
        run_cmd("tmo_edge_out", 40'h52_00_41_00_00, 3, 1, TMO);
        check_bytes("tmo_edge_out_bytes");
        check_val("tmo_edge_out_writes", 64'(wr_count - wr0), 64'd0);

        // Extra byte during a 16-word read
        exp_q.delete();
        cmd = 40'h52_00_40_0F_00;
        model_cmd(cmd);
        got_q.delete();
        for (int k = 0; k < 4; k++) send_byte(cmd[39-8*k -: 8], 0);
        wait_bytes("ovr_pre", 6);
        check_val("ovr_before", 64'(overrun), 64'd0);
        send_byte(8'h55, 0);
        check_val("ovr_set", 64'(overrun), 64'd1);
        wait_bytes("ovr_stream", exp_q.size());
        repeat (12) begin
            @(posedge clk); #1;
        end
        check_bytes("ovr_stream_bytes");
        check_val("ovr_sticky", 64'(overrun), 64'd1);

        // Reset in the middle of a read stream
        got_q.delete();
        cmd = 40'h52_00_00_0F_00;
        for (int k = 0; k < 4; k++) send_byte(cmd[39-8*k -: 8], 0);
        wait_bytes("rst_pre", 4);
        wr0 = wr_count;
        reset = 1'b0;
        #1;
        check_val("rst_mid_outputs",
                  {tx_strobe, tx_data, spram_wren, spram_addr,
                   spram_wdata, busy, overrun}, 64'd0);
        repeat (3) begin
            @(posedge clk); #1;
        end
        n0 = got_q.size();
        reset = 1'b1;
        repeat (40) begin
            @(posedge clk); #1;
        end
        check_val("rst_no_more_tx", 64'(got_q.size()), 64'(n0));
        check_val("rst_no_write", 64'(wr_count - wr0), 64'd0);
        check_val("rst_busy", 64'(busy), 64'd0);

        exp_q.delete();
        model_cmd(40'h52_3F_FF_01_00);
        run_cmd("post_rst", 40'h52_3F_FF_01_00, 4, -1, 0);
        check_bytes("post_rst_bytes");

        check_val("no_adjacent_strobes", 64'(dbl), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
